// File: rtl/shift_deser_32_pkg.sv
// Shared definitions for the 32-bit shift-register deserializer.
package shift_deser_32_pkg;

    localparam int SHIFT_WIDTH = 32;
    localparam int SHIFT_CNT_W = $clog2(SHIFT_WIDTH) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage

// File: rtl/shift_deser_32_hold_reg.sv
// One-entry valid/ready holding register; a word arriving while the entry is
// full and not being read is dropped and flagged as a sticky overrun.
module shift_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             pdata_ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             overrun
);

    logic pop;

    assign pop = valid & pdata_ready;

    // A load wins over a pop in the same cycle, so back-to-back words stream through.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            dout    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && (!valid || pop)) begin
                dout  <= din;
                valid <= 1'b1;
            end else if (pop) begin
                valid <= 1'b0;
            end

            if (start) begin
                overrun <= 1'b0;
            end else if (load && valid && !pdata_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_deser_32.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words from a bit stream,
// MSB- or LSB-first, and hands them off through a one-entry holding register.
module shift_deser_32
    import shift_deser_32_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int CNT_W = SHIFT_CNT_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             msb_first,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] pdata_out,
    output logic             pdata_valid,
    input  logic             pdata_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_base;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CNT_W-1:0] cnt_base;
    logic             msb_lat;
    logic             dir;
    logic             take;
    logic             complete;

    // A start cycle begins from an empty word, so its own bit lands as bit 0.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RECV;
        end else if (stop && (state == ST_RECV)) begin
            state_nxt = ST_IDLE;
        end

        take      = sin_valid && (start || ((state == ST_RECV) && !stop));
        dir       = start ? msb_first : msb_lat;
        sreg_base = start ? '0 : sreg;
        cnt_base  = start ? '0 : bit_cnt;
        sreg_nxt  = dir ? {sreg_base[WIDTH-2:0], sin} : {sin, sreg_base[WIDTH-1:1]};
        complete  = take && (cnt_base == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            msb_lat <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                msb_lat <= msb_first;
            end
            if (take) begin
                sreg    <= sreg_nxt;
                bit_cnt <= complete ? '0 : cnt_base + CNT_W'(1);
            end else if (start || (stop && (state == ST_RECV))) begin
                sreg    <= '0;
                bit_cnt <= '0;
            end
        end
    end

    assign busy = (state == ST_RECV);

    shift_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .load       (complete),
        .din        (sreg_nxt),
        .pdata_ready(pdata_ready),
        .dout       (pdata_out),
        .valid      (pdata_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_shift_deser_32.sv
// Randomized scoreboard bench for shift_deser_32 against a bit-queue reference model.
module tb_shift_deser_32;

    logic        clk;
    logic        clear;
    logic        start;
    logic        stop;
    logic        msb_first;
    logic        sin;
    logic        sin_valid;
    logic [31:0] pdata_out;
    logic        pdata_valid;
    logic        pdata_ready;
    logic        busy;
    logic [5:0]  bit_cnt;
    logic        overrun;

    int vectors;
    int miscompares;

    bit          bitq[$];
    logic [31:0] expq[$];
    logic        m_busy;
    logic        m_msb;
    logic        m_valid;
    logic [31:0] m_word;
    logic        m_ovr;

    shift_deser_32 dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .msb_first  (msb_first),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .pdata_out  (pdata_out),
        .pdata_valid(pdata_valid),
        .pdata_ready(pdata_ready),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bitq.delete();
        expq.delete();
        m_busy  = 1'b0;
        m_msb   = 1'b0;
        m_valid = 1'b0;
        m_word  = '0;
        m_ovr   = 1'b0;
    endtask

    // Reference behaviour for one clock edge, using the inputs present at that edge.
    task automatic model_edge();
        logic        pop;
        logic        take;
        logic        done;
        logic [31:0] w;
        pop  = m_valid && pdata_ready;
        take = sin_valid && (start || (m_busy && !stop));
        done = 1'b0;
        w    = '0;
        if (start) begin
            bitq.delete();
            m_msb  = msb_first;
            m_ovr  = 1'b0;
            m_busy = 1'b1;
        end else if (stop && m_busy) begin
            bitq.delete();
            m_busy = 1'b0;
        end
        if (take) begin
            bitq.push_back(sin);
            if (bitq.size() == 32) begin
                for (int i = 0; i < 32; i++) begin
                    if (m_msb) w = w + (32'(bitq[i]) << (31 - i));
                    else       w = w + (32'(bitq[i]) << i);
                end
                bitq.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || pop) begin
                m_word  = w;
                m_valid = 1'b1;
                expq.push_back(w);
            end else begin
                m_ovr = 1'b1;
            end
        end else if (pop) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic sp, input logic msb,
                                  input logic b, input logic v, input logic r);
        start       = st;
        stop        = sp;
        msb_first   = msb;
        sin         = b;
        sin_valid   = v;
        pdata_ready = r;
        @(posedge clk);
        if (clear) model_edge();
        #1;
    endtask

    task automatic send_word(input logic [31:0] word, input logic msb, input logic with_start,
                             input logic r, input logic r_last, input int gap_pct);
        logic [31:0] wv;
        wv = word;
        for (int i = 0; i < 32; i++) begin
            while (i > 0 && gap_pct > 0 && ($urandom_range(99) < gap_pct))
                apply_stimulus(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0, r);
            apply_stimulus(with_start && (i == 0), 1'b0, msb, msb ? wv[31 - i] : wv[i], 1'b1,
                           (i == 31) ? r_last : r);
        end
    endtask

    task automatic send_bits(input int n, input logic with_start, input logic r);
        for (int i = 0; i < n; i++)
            apply_stimulus(with_start && (i == 0), 1'b0, 1'($urandom), 1'($urandom), 1'b1, r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0, r);
    endtask

    // Monitor: per-cycle status checks plus scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (clear) begin
            check_output("busy", 64'(busy), 64'(m_busy));
            check_output("bit_cnt", 64'(bit_cnt), 64'(bitq.size()));
            check_output("pdata_valid", 64'(pdata_valid), 64'(m_valid));
            check_output("overrun", 64'(overrun), 64'(m_ovr));
            if (m_valid) check_output("pdata_out_held", 64'(pdata_out), 64'(m_word));
            if (pdata_valid && pdata_ready) begin
                if (expq.size() == 0) check_output("unexpected_word", 64'(pdata_out), 64'hDEAD_0000_0000);
                else check_output("pop_word", 64'(pdata_out), 64'(expq.pop_front()));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        clear       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        msb_first   = 1'b0;
        sin         = 1'b0;
        sin_valid   = 1'b0;
        pdata_ready = 1'b0;
        #3;
        check_output("reset_pdata_out", 64'(pdata_out), 64'h0);
        check_output("reset_pdata_valid", 64'(pdata_valid), 64'h0);
        check_output("reset_busy", 64'(busy), 64'h0);
        check_output("reset_bit_cnt", 64'(bit_cnt), 64'h0);
        check_output("reset_overrun", 64'(overrun), 64'h0);
        @(posedge clk);
        #1 clear = 1'b1;

        $display("[TB] LSB-first word, ready high");
        send_word(32'hA5C3_0F01, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        idle(3, 1'b1);

        $display("[TB] MSB-first word with sin_valid gaps");
        send_word(32'h8000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 40);
        idle(3, 1'b1);

        $display("[TB] stalled consumer, overrun");
        send_word(32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send_word(32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(2, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);

        $display("[TB] ready on completion edge of second word");
        send_word(32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send_word(32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle(3, 1'b0);
        idle(2, 1'b1);

        $display("[TB] restart mid-word, stop mid-word");
        send_bits(17, 1'b1, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        idle(2, 1'b1);
        send_bits(5, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("[TB] random traffic");
        for (int k = 0; k < 1500; k++)
            apply_stimulus($urandom_range(99) == 0, $urandom_range(149) == 0, 1'($urandom),
                           1'($urandom), $urandom_range(3) != 0, $urandom_range(2) != 0);
        idle(3, 1'b1);

        $display("[TB] asynchronous clear mid-word");
        send_word(32'h0F0F_00FF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send_bits(10, 1'b0, 1'b0);
        #1 clear = 1'b0;
        #1;
        check_output("aclr_pdata_out", 64'(pdata_out), 64'h0);
        check_output("aclr_pdata_valid", 64'(pdata_valid), 64'h0);
        check_output("aclr_busy", 64'(busy), 64'h0);
        check_output("aclr_bit_cnt", 64'(bit_cnt), 64'h0);
        check_output("aclr_overrun", 64'(overrun), 64'h0);
        model_reset();
        @(posedge clk);
        #2 clear = 1'b1;
        @(posedge clk);
        #1;
        idle(2, 1'b1);
        send_word(32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        idle(3, 1'b1);

        check_output("queue_drained", 64'(expq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
